// File: rtl/bus_memory_pipelined_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_memory_pipelined_if
//  Purpose  : Savestate-bus side of the bus/memory bridge. The host drives
//             the address, write data and write flag. The bridge returns the
//             read data, the completion flag and the window-hit flag.
//  Signals  : bus_in     - write data             (master -> slave)
//             bus_addr   - bus address            (master -> slave)
//             bus_wren   - access is a write      (master -> slave)
//             bus_out    - registered read data   (slave  -> master)
//             bus_ready  - access complete        (slave  -> master)
//             mem_active - address hits window    (slave  -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface bus_memory_pipelined_if #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_ADDR_WIDTH = 21
);
   logic [BUS_DATA_WIDTH-1:0] bus_in;
   logic [BUS_ADDR_WIDTH-1:0] bus_addr;
   logic                      bus_wren;
   logic [BUS_DATA_WIDTH-1:0] bus_out;
   logic                      bus_ready;
   logic                      mem_active;

   modport master (
      output bus_in, bus_addr, bus_wren,
      input  bus_out, bus_ready, mem_active
   );

   modport slave (
      input  bus_in, bus_addr, bus_wren,
      output bus_out, bus_ready, mem_active
   );
endinterface
`default_nettype wire

// File: rtl/bus_memory_pipelined.sv
`default_nettype none
// ============================================================================
//  Module   : bus_memory_pipelined
//  Purpose  : Maps the savestate-bus window [ADDRESS_MIN, ADDRESS_MAX) onto a
//             narrower single-port memory. Each bus word is moved as WORDS
//             consecutive memory words, least-significant word first. Reads
//             tolerate a fixed memory latency of 0..3 cycles.
//  Ports    : clk              - clock
//             reset            - synchronous, active-high reset
//             bus              - savestate bus (slave modport)
//             mem_addr         - memory word address
//             mem_current_data - memory read data
//             mem_new_data     - memory write data
//             mem_wren         - memory write strobe
//  Revision : 1.0 - initial release
// ============================================================================
module bus_memory_pipelined #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_ADDR_WIDTH = 21,
   parameter int MEM_DATA_WIDTH = 4,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int MEM_DEPTH      = 2**MEM_ADDR_WIDTH,
   parameter int READ_LATENCY   = 0,
   parameter int ADDRESS_MIN    = 0,
   parameter int ADDRESS_MAX    = 64
) (
   input  wire logic                      clk,
   input  wire logic                      reset,
   bus_memory_pipelined_if.slave          bus,
   output logic [MEM_ADDR_WIDTH-1:0]      mem_addr,
   input  wire logic [MEM_DATA_WIDTH-1:0] mem_current_data,
   output logic [MEM_DATA_WIDTH-1:0]      mem_new_data,
   output logic                           mem_wren
);
   localparam int c_words = BUS_DATA_WIDTH / MEM_DATA_WIDTH;
   localparam int c_cnt_w = (c_words > 1) ? $clog2(c_words) : 1;

   localparam logic [c_cnt_w-1:0]        c_last     = c_cnt_w'(c_words - 1);
   localparam logic [BUS_ADDR_WIDTH-1:0] c_addr_min = BUS_ADDR_WIDTH'(ADDRESS_MIN);
   // One extra bit so an exclusive end of 2**BUS_ADDR_WIDTH is representable.
   localparam logic [BUS_ADDR_WIDTH:0]   c_addr_max = (BUS_ADDR_WIDTH + 1)'(ADDRESS_MAX);
   localparam logic [MEM_ADDR_WIDTH:0]   c_depth    = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_write = 2'd1;
   localparam logic [1:0] c_st_read  = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   generate
      if (BUS_DATA_WIDTH % MEM_DATA_WIDTH != 0) begin : g_err_ratio
         $error("BUS_DATA_WIDTH must be a multiple of MEM_DATA_WIDTH");
      end
      if (c_words < 1 || (c_words & (c_words - 1)) != 0) begin : g_err_pow2
         $error("BUS_DATA_WIDTH/MEM_DATA_WIDTH must be a power of two");
      end
      if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_err_latency
         $error("READ_LATENCY must be in 0..3");
      end
      if (ADDRESS_MAX <= ADDRESS_MIN) begin : g_err_window
         $error("ADDRESS_MAX must be greater than ADDRESS_MIN");
      end
   endgenerate

   logic [1:0]                r_state;
   logic [1:0]                w_state_next;
   logic [BUS_ADDR_WIDTH-1:0] r_cur_addr;
   logic [c_cnt_w-1:0]        r_issue_cnt;
   logic                      r_issue_done;
   logic [BUS_DATA_WIDTH-1:0] r_buf;
   logic [BUS_DATA_WIDTH-1:0] r_bus_out;
   logic [BUS_DATA_WIDTH-1:0] w_buf_next;

   logic                      w_active;
   logic [BUS_ADDR_WIDTH-1:0] w_base;
   logic                      w_in_depth;
   logic                      w_abort;
   logic                      w_issue;
   logic                      w_last_issue;
   logic                      w_cap_valid;
   logic [c_cnt_w-1:0]        w_cap_slot;
   logic                      w_cap_zero;
   logic                      w_last_cap;

   // Window decode and memory address generation.
   assign w_active       = (bus.bus_addr >= c_addr_min) && ({1'b0, bus.bus_addr} < c_addr_max);
   assign w_base         = w_active ? (bus.bus_addr - c_addr_min) : '0;
   assign bus.mem_active = w_active;

   generate
      if (c_words > 1) begin : g_addr_multi
         assign mem_addr = MEM_ADDR_WIDTH'({w_base, r_issue_cnt});
      end else begin : g_addr_single
         assign mem_addr = MEM_ADDR_WIDTH'(w_base);
      end
   endgenerate

   assign w_in_depth   = ({1'b0, mem_addr} < c_depth);
   // Any address movement while an access is in flight cancels it.
   assign w_abort      = (r_state != c_st_idle) && (!w_active || (bus.bus_addr != r_cur_addr));
   assign w_issue      = (r_state == c_st_read) && !r_issue_done;
   assign w_last_issue = (r_issue_cnt == c_last);

   // Read return path: each issued word carries its slot index and an
   // out-of-depth flag for READ_LATENCY cycles, to meet the returning data.
   generate
      if (READ_LATENCY == 0) begin : g_lat_zero
         assign w_cap_valid = w_issue;
         assign w_cap_slot  = r_issue_cnt;
         assign w_cap_zero  = !w_in_depth;
      end else begin : g_lat_pipe
         logic [READ_LATENCY-1:0] r_pipe_vld;
         logic [READ_LATENCY-1:0] r_pipe_zero;
         logic [c_cnt_w-1:0]      r_pipe_slot [READ_LATENCY];

         always_ff @(posedge clk) begin
            if (reset || w_abort) begin
               r_pipe_vld <= '0;
            end else begin
               r_pipe_vld[0] <= w_issue;
               for (int i = 1; i < READ_LATENCY; i++) begin
                  r_pipe_vld[i] <= r_pipe_vld[i-1];
               end
            end
            r_pipe_slot[0] <= r_issue_cnt;
            r_pipe_zero[0] <= !w_in_depth;
            for (int i = 1; i < READ_LATENCY; i++) begin
               r_pipe_slot[i] <= r_pipe_slot[i-1];
               r_pipe_zero[i] <= r_pipe_zero[i-1];
            end
         end

         assign w_cap_valid = r_pipe_vld[READ_LATENCY-1];
         assign w_cap_slot  = r_pipe_slot[READ_LATENCY-1];
         assign w_cap_zero  = r_pipe_zero[READ_LATENCY-1];
      end
   endgenerate

   assign w_last_cap = w_cap_valid && (w_cap_slot == c_last);

   // Buffer with the returning word merged in; also the bus_out source on the
   // final capture so the last word is not a cycle late.
   always_comb begin
      w_buf_next = r_buf;
      if (w_cap_valid) begin
         w_buf_next[w_cap_slot*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] =
            w_cap_zero ? '0 : mem_current_data;
      end
   end

   // FSM: state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_active) begin
               w_state_next = bus.bus_wren ? c_st_write : c_st_read;
            end
         end
         c_st_write: begin
            if (w_abort) begin
               w_state_next = c_st_idle;
            end else if (w_last_issue) begin
               w_state_next = c_st_done;
            end
         end
         c_st_read: begin
            if (w_abort) begin
               w_state_next = c_st_idle;
            end else if (w_last_cap) begin
               w_state_next = c_st_done;
            end
         end
         default: begin
            if (w_abort) begin
               w_state_next = c_st_idle;
            end
         end
      endcase
   end

   // FSM: outputs. The write strobe is gated the same cycle an abort or reset
   // is seen so a moved address never receives a stray write.
   always_comb begin
      mem_wren      = (r_state == c_st_write) && !w_abort && !reset && w_in_depth;
      bus.bus_ready = (r_state == c_st_done) && !w_abort;
   end

   assign mem_new_data = r_buf[r_issue_cnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
   assign bus.bus_out  = r_bus_out;

   // Datapath: latched address, word counter, serialisation buffer, bus_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur_addr   <= '0;
         r_issue_cnt  <= '0;
         r_issue_done <= 1'b0;
         r_buf        <= '0;
         r_bus_out    <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_issue_cnt  <= '0;
               r_issue_done <= 1'b0;
               if (w_active) begin
                  r_cur_addr <= bus.bus_addr;
                  if (bus.bus_wren) begin
                     r_buf <= bus.bus_in;
                  end
               end
            end
            c_st_write: begin
               if (w_abort || w_last_issue) begin
                  r_issue_cnt <= '0;
               end else begin
                  r_issue_cnt <= r_issue_cnt + c_cnt_w'(1);
               end
            end
            c_st_read: begin
               r_buf <= w_buf_next;
               if (w_last_cap && !w_abort) begin
                  r_bus_out <= w_buf_next;
               end
               if (w_abort) begin
                  r_issue_cnt  <= '0;
                  r_issue_done <= 1'b0;
               end else if (w_issue) begin
                  if (w_last_issue) begin
                     r_issue_cnt  <= '0;
                     r_issue_done <= 1'b1;
                  end else begin
                     r_issue_cnt <= r_issue_cnt + c_cnt_w'(1);
                  end
               end
            end
            default: begin
               r_issue_cnt <= '0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_bus_memory_pipelined.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_memory_pipelined
//  Purpose  : Self-checking bench for bus_memory_pipelined. Three bridges
//             share one bus stimulus: dut0 (latency 0), dut1 (latency 2) and
//             dut2 (latency 0, depth 0x28, memory reads as all-ones).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_memory_pipelined;
   localparam logic [63:0] c_d1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] c_d3 = 64'h5A5A5A5A5A5A5A5A;
   localparam logic [63:0] c_d4 = 64'hCAFEF00DDEADBEEF;

   logic        clk;
   logic        rst;
   logic [15:0] b_addr;
   logic [63:0] b_in;
   logic        b_wren;

   int total;
   int bad;

   bus_memory_pipelined_if #(.BUS_DATA_WIDTH(64), .BUS_ADDR_WIDTH(16)) if0 ();
   bus_memory_pipelined_if #(.BUS_DATA_WIDTH(64), .BUS_ADDR_WIDTH(16)) if1 ();
   bus_memory_pipelined_if #(.BUS_DATA_WIDTH(64), .BUS_ADDR_WIDTH(16)) if2 ();

   assign if0.bus_addr = b_addr;
   assign if0.bus_in   = b_in;
   assign if0.bus_wren = b_wren;
   assign if1.bus_addr = b_addr;
   assign if1.bus_in   = b_in;
   assign if1.bus_wren = b_wren;
   assign if2.bus_addr = b_addr;
   assign if2.bus_in   = b_in;
   assign if2.bus_wren = b_wren;

   logic [9:0] m0_addr, m1_addr, m2_addr;
   logic [3:0] m0_wdata, m1_wdata, m2_wdata;
   logic [3:0] m0_rdata, m1_rdata, m2_rdata;
   logic       m0_wren, m1_wren, m2_wren;

   bus_memory_pipelined #(
      .BUS_DATA_WIDTH(64), .BUS_ADDR_WIDTH(16), .MEM_DATA_WIDTH(4), .MEM_ADDR_WIDTH(10),
      .MEM_DEPTH(1024), .READ_LATENCY(0), .ADDRESS_MIN(16), .ADDRESS_MAX(64)
   ) dut0 (
      .clk(clk), .reset(rst), .bus(if0.slave), .mem_addr(m0_addr),
      .mem_current_data(m0_rdata), .mem_new_data(m0_wdata), .mem_wren(m0_wren)
   );

   bus_memory_pipelined #(
      .BUS_DATA_WIDTH(64), .BUS_ADDR_WIDTH(16), .MEM_DATA_WIDTH(4), .MEM_ADDR_WIDTH(10),
      .MEM_DEPTH(1024), .READ_LATENCY(2), .ADDRESS_MIN(16), .ADDRESS_MAX(64)
   ) dut1 (
      .clk(clk), .reset(rst), .bus(if1.slave), .mem_addr(m1_addr),
      .mem_current_data(m1_rdata), .mem_new_data(m1_wdata), .mem_wren(m1_wren)
   );

   bus_memory_pipelined #(
      .BUS_DATA_WIDTH(64), .BUS_ADDR_WIDTH(16), .MEM_DATA_WIDTH(4), .MEM_ADDR_WIDTH(10),
      .MEM_DEPTH(40), .READ_LATENCY(0), .ADDRESS_MIN(16), .ADDRESS_MAX(64)
   ) dut2 (
      .clk(clk), .reset(rst), .bus(if2.slave), .mem_addr(m2_addr),
      .mem_current_data(m2_rdata), .mem_new_data(m2_wdata), .mem_wren(m2_wren)
   );

   // Memory models.
   logic [3:0] mem0 [0:1023];
   logic [3:0] mem1 [0:1023];
   logic [3:0] r1a, r1b;
   int         w2_cnt;
   int         w2_oob;

   assign m0_rdata = mem0[m0_addr];
   assign m1_rdata = r1b;
   assign m2_rdata = 4'hF;

   always @(posedge clk) begin
      if (m0_wren) mem0[m0_addr] <= m0_wdata;
   end

   always @(posedge clk) begin
      if (m1_wren) mem1[m1_addr] <= m1_wdata;
      r1a <= mem1[m1_addr];
      r1b <= r1a;
   end

   always @(posedge clk) begin
      if (m2_wren) begin
         w2_cnt <= w2_cnt + 1;
         if (m2_addr >= 10'h028) w2_oob <= w2_oob + 1;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        exp_active;
      logic [9:0]  exp_maddr;
   } win_vec_t;

   win_vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap();
      b_addr = 16'h0000;
      b_wren = 1'b0;
      tick();
      tick();
   endtask

   function automatic logic [3:0] nib(input logic [63:0] d, input int i);
      return d[4*i +: 4];
   endfunction

   initial begin
      int c0;
      int o0;
      logic [15:0] bad_addrs [2];

      vecs[0] = '{addr: 16'h000F, exp_active: 1'b0, exp_maddr: 10'h000};
      vecs[1] = '{addr: 16'h0010, exp_active: 1'b1, exp_maddr: 10'h000};
      vecs[2] = '{addr: 16'h0012, exp_active: 1'b1, exp_maddr: 10'h020};
      vecs[3] = '{addr: 16'h003F, exp_active: 1'b1, exp_maddr: 10'h2F0};
      vecs[4] = '{addr: 16'h0040, exp_active: 1'b0, exp_maddr: 10'h000};
      vecs[5] = '{addr: 16'hFFFF, exp_active: 1'b0, exp_maddr: 10'h000};
      bad_addrs[0] = 16'h0040;
      bad_addrs[1] = 16'h000F;

      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      b_addr = 16'h0000;
      b_in   = '0;
      b_wren = 1'b0;
      repeat (3) tick();

      // Reset state.
      @(negedge clk);
      chk("rst_out0",   if0.bus_out,   64'h0);
      chk("rst_rdy0",   if0.bus_ready, 1'b0);
      chk("rst_wren0",  m0_wren,       1'b0);
      chk("rst_out1",   if1.bus_out,   64'h0);
      chk("rst_rdy1",   if1.bus_ready, 1'b0);
      chk("rst_out2",   if2.bus_out,   64'h0);
      tick();

      // Window decode and base address, with the bridge held in reset.
      for (int v = 0; v < 6; v++) begin
         b_addr = vecs[v].addr;
         b_wren = 1'b1;
         @(negedge clk);
         chk($sformatf("win_active[%0d]", v), if0.mem_active, vecs[v].exp_active);
         chk($sformatf("win_maddr[%0d]", v),  m0_addr,        vecs[v].exp_maddr);
         chk($sformatf("win_rdy[%0d]", v),    if0.bus_ready,  1'b0);
         chk($sformatf("win_wren[%0d]", v),   m0_wren,        1'b0);
         tick();
      end
      rst = 1'b0;
      idle_gap();

      // Write 0x0123456789ABCDEF at bus address 0x12.
      c0 = w2_cnt;
      o0 = w2_oob;
      b_addr = 16'h0012;
      b_in   = c_d1;
      b_wren = 1'b1;
      for (int k = 0; k <= 19; k++) begin
         if (k == 18) begin
            b_in   = ~c_d1;
            b_wren = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("wr_wren[%0d]", k), m0_wren, (k >= 1 && k <= 16));
         if (k >= 1 && k <= 16) begin
            chk($sformatf("wr_maddr[%0d]", k), m0_addr,  10'h020 + 10'(k - 1));
            chk($sformatf("wr_wdata[%0d]", k), m0_wdata, nib(c_d1, k - 1));
         end
         chk($sformatf("wr_rdy[%0d]", k), if0.bus_ready, (k >= 17));
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("wr_mem[%0d]", i), mem0[10'h020 + 10'(i)], nib(c_d1, i));
      end
      chk("depth_wr_cnt", 64'(w2_cnt - c0), 64'd8);
      chk("depth_wr_oob", 64'(w2_oob - o0), 64'd0);
      idle_gap();

      // Read back at 0x12.
      b_addr = 16'h0012;
      b_wren = 1'b0;
      for (int k = 0; k <= 21; k++) begin
         @(negedge clk);
         chk($sformatf("rd1_wren[%0d]", k), m1_wren,       1'b0);
         chk($sformatf("rd1_rdy[%0d]", k),  if1.bus_ready, (k >= 19));
         if (k == 19 || k == 21) chk($sformatf("rd1_out[%0d]", k), if1.bus_out, c_d1);
         if (k == 16) chk("rd0_rdy16", if0.bus_ready, 1'b0);
         if (k == 17) begin
            chk("rd0_rdy17", if0.bus_ready, 1'b1);
            chk("rd0_out17", if0.bus_out,   c_d1);
            chk("rd2_out17", if2.bus_out,   64'h00000000FFFFFFFF);
         end
         tick();
      end
      idle_gap();

      // Write aborted by an address change after five words.
      b_addr = 16'h0012;
      b_in   = c_d3;
      b_wren = 1'b1;
      for (int k = 0; k <= 24; k++) begin
         if (k == 6) b_addr = 16'h0013;
         @(negedge clk);
         if (k >= 1 && k <= 5) begin
            chk($sformatf("ab_wren[%0d]", k),  m0_wren, 1'b1);
            chk($sformatf("ab_maddr[%0d]", k), m0_addr, 10'h020 + 10'(k - 1));
         end
         if (k == 6) chk("ab_wren6", m0_wren, 1'b0);
         if (k == 7) begin
            chk("ab_wren7",  m0_wren,       1'b0);
            chk("ab_rdy7",   if0.bus_ready, 1'b0);
            chk("ab_maddr7", m0_addr,       10'h030);
            chk("ab_out7",   if0.bus_out,   c_d1);
         end
         if (k == 8) begin
            chk("ab_wren8",  m0_wren, 1'b1);
            chk("ab_maddr8", m0_addr, 10'h030);
         end
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ab_mem[%0d]", i), mem0[10'h020 + 10'(i)],
             (i < 5) ? nib(c_d3, i) : nib(c_d1, i));
      end

      // Addresses just outside the window.
      for (int a = 0; a < 2; a++) begin
         b_addr = bad_addrs[a];
         b_in   = c_d1;
         b_wren = 1'b1;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("oob_act[%0d][%0d]", a, k),   if0.mem_active, 1'b0);
            chk($sformatf("oob_rdy[%0d][%0d]", a, k),   if0.bus_ready,  1'b0);
            chk($sformatf("oob_wren[%0d][%0d]", a, k),  m0_wren,        1'b0);
            chk($sformatf("oob_maddr[%0d][%0d]", a, k), m0_addr,        10'h000);
            tick();
         end
      end

      // Reset during write cycle 8, address held throughout.
      b_addr = 16'h0012;
      b_in   = c_d4;
      b_wren = 1'b1;
      for (int k = 0; k <= 11; k++) begin
         if (k == 8) rst = 1'b1;
         if (k == 9) rst = 1'b0;
         @(negedge clk);
         if (k >= 1 && k <= 7) chk($sformatf("rs_wren[%0d]", k), m0_wren, 1'b1);
         if (k == 9) begin
            chk("rs_wren9", m0_wren,       1'b0);
            chk("rs_rdy9",  if0.bus_ready, 1'b0);
            chk("rs_out9",  if0.bus_out,   64'h0);
            chk("rs_out9b", if1.bus_out,   64'h0);
         end
         if (k == 10) begin
            chk("rs_wren10",  m0_wren,  1'b1);
            chk("rs_maddr10", m0_addr,  10'h020);
            chk("rs_wdata10", m0_wdata, nib(c_d4, 0));
         end
         if (k == 11) chk("rs_maddr11", m0_addr, 10'h021);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/bus_memory_pipelined.md
Name: bus_memory_pipelined

Overview:
- Savestate-bus bridge that maps one window of savestate bus addresses onto a narrower single-port memory.
- Each bus word is serialised into WORDS = BUS_DATA_WIDTH/MEM_DATA_WIDTH consecutive memory words.
- Adds to the existing bus/memory bridge:
  - a configurable memory read latency, for registered BRAM outputs;
  - a bus_ready completion flag;
  - a MEM_DEPTH bound for windows that are not a power-of-two size;
  - an explicit synchronous reset.
- Instantiated once per core memory (RAM, VRAM, etc.) on the savestate bus.

Parameters:
- BUS_DATA_WIDTH, default SS_DATA_WIDTH: savestate bus data width. Must be a multiple of MEM_DATA_WIDTH.
- BUS_ADDR_WIDTH, default SS_BUS_WIDTH: savestate bus address width.
- MEM_DATA_WIDTH, default 4: memory word width. WORDS = BUS_DATA_WIDTH/MEM_DATA_WIDTH must be a power of two, 1 or greater.
- MEM_ADDR_WIDTH, default 10: memory address width.
- MEM_DEPTH, default 2**MEM_ADDR_WIDTH: number of valid memory words.
- READ_LATENCY, default 0: cycles from mem_addr to valid mem_current_data. Legal range 0..3.
- ADDRESS_MIN: first bus address of the window (inclusive).
- ADDRESS_MAX: end of the window (exclusive).

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- bus_in, in, BUS_DATA_WIDTH: write data.
- bus_addr, in, BUS_ADDR_WIDTH: bus address.
- bus_wren, in, 1: operation is a write (sampled at start).
- bus_out, out, BUS_DATA_WIDTH: read data (registered).
- bus_ready, out, 1: current bus access is complete.
- mem_addr, out, MEM_ADDR_WIDTH: memory word address.
- mem_current_data, in, MEM_DATA_WIDTH: memory read data.
- mem_new_data, out, MEM_DATA_WIDTH: memory write data.
- mem_wren, out, 1: memory write strobe.
- mem_active, out, 1: bus_addr is inside the window (combinational).

Behaviour:
- Reset: state IDLE, all counters 0, valid pipeline cleared, bus_out=0, bus_ready=0, mem_wren=0. Reset has priority over every other event in the same cycle.
- mem_active = (bus_addr >= ADDRESS_MIN) && (bus_addr < ADDRESS_MAX).
- Address generation:
  - base = bus_addr - ADDRESS_MIN, or 0 when the address is out of the window.
  - mem_addr = low MEM_ADDR_WIDTH bits of {base, issue_cnt}. When WORDS=1, mem_addr = base.
- States: IDLE, WRITE, READ, DONE.
- IDLE: if mem_active, latch bus_addr into cur_addr.
  - If bus_wren: buffer <= bus_in, go to WRITE.
  - Otherwise: go to READ.
  - Call this detection cycle 0.
- WRITE:
  - Cycles 1..WORDS: mem_wren=1, issue_cnt=k-1, mem_new_data = buffer word k-1 (LSB word first).
  - mem_wren is forced to 0 for any word whose mem_addr >= MEM_DEPTH.
  - After the last word, go to DONE. bus_ready=1 from cycle WORDS+1.
- READ:
  - Cycles 1..WORDS: issue addresses with issue_cnt 0..WORDS-1. mem_wren=0 throughout.
  - A READ_LATENCY-deep valid/offset pipeline tags each issue. When a tag emerges, mem_current_data is written into buffer word slot[tag]. Words with addr >= MEM_DEPTH are captured as 0.
  - After the last capture, bus_out <= assembled buffer and the state goes to DONE.
  - bus_ready=1 from cycle WORDS+READ_LATENCY+1.
- DONE:
  - bus_ready=1, bus_out held, mem_wren=0.
  - Stays in DONE while bus_addr == cur_addr. Changes to bus_in or bus_wren are ignored.
- Abort, checked every cycle outside IDLE: triggered when ~mem_active or bus_addr != cur_addr.
  - Next cycle: state IDLE, mem_wren=0, counters and valid pipeline cleared, bus_ready=0.
  - bus_out keeps its last completed value.
  - A new in-window address is detected on the cycle after the return to IDLE.
- A write aborted mid-sequence leaves the words already written modified. No rollback.
- bus_ready is also 0 in IDLE and whenever mem_active=0.
- Back-to-back accesses: an address change from DONE costs one IDLE cycle before the next detection.
- Elaboration errors:
  - BUS_DATA_WIDTH % MEM_DATA_WIDTH != 0.
  - WORDS not a power of two.
  - READ_LATENCY > 3.
  - ADDRESS_MAX <= ADDRESS_MIN.

Test Plan:
1. Write, BUS 64/MEM 4, READ_LATENCY=0, ADDRESS_MIN=0x10, bus_addr=0x12, bus_in=0x0123456789ABCDEF, bus_wren=1 → mem_wren high cycles 1..16; mem_addr 0x20..0x2F; mem_new_data F,E,D,…,1,0; bus_ready=1 at cycle 17.
2. Read back from a memory model holding the case-1 data, READ_LATENCY=2 → no mem_wren; bus_ready rises at cycle 19; bus_out=0x0123456789ABCDEF; bus_ready stays 1 while the address is held.
3. Abort: change bus_addr 0x12→0x13 during write cycle 5 → mem_wren=0 the next cycle; IDLE for one cycle; new access starts with mem_addr 0x30; words 0x20..0x24 modified, 0x25..0x2F untouched.
4. Bounds: bus_addr=ADDRESS_MAX, or ADDRESS_MIN-1 → mem_active=0, bus_ready=0, mem_wren never asserted, mem_addr=0.
5. MEM_DEPTH=0x28, read at bus_addr 0x12 with memory returning 0xF everywhere → bus_out=0x00000000FFFFFFFF; a write at the same address asserts mem_wren for 0x20..0x27 only.
6. Assert reset at write cycle 8 → next cycle mem_wren=0, bus_ready=0, bus_out=0; after reset releases with the address held, the write restarts at mem_addr 0x20.
